comparator_seq_ctrl: RTL and testbench

//  Sequencer for a multi-word magnitude compare built from one 2-bit comparator slice.

---
 rtl/cmp_ctrl_pkg.sv | 32 +++
 rtl/cmp_slice2.sv | 22 ++
 rtl/comparator_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_comparator_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cmp_ctrl_pkg
// Shared definitions for the sequential wide magnitude comparator:
//   - FSM state encoding
//   - one-hot result codes {gt, eq, lt}
//   - width helpers for the slice count and the slice counter
// ---------------------------------------------------------------------------
package cmp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Result codes packed as {gt, eq, lt}; RES_NONE means "not decided yet".
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    // Number of 2-bit slices in a w-bit operand.
    function automatic int nslice(input int w);
        return w / 2;
    endfunction

    // Width of a counter able to hold 0..nslice(w).
    function automatic int cw_of(input int w);
        return $clog2(w / 2 + 1);
    endfunction

endpackage

// File: rtl/cmp_slice2.sv
// ---------------------------------------------------------------------------
// cmp_slice2
// Combinational unsigned magnitude compare of two 2-bit slices.
// Ports:
//   i_a, i_b : 2-bit slices to compare
//   o_gt     : i_a > i_b
//   o_eq     : i_a == i_b
//   o_lt     : i_a < i_b
// ---------------------------------------------------------------------------
module cmp_slice2 (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic       o_gt,
    output logic       o_eq,
    output logic       o_lt
);

    assign o_gt = (i_a > i_b);
    assign o_eq = (i_a == i_b);
    assign o_lt = (i_a < i_b);

endmodule

// File: rtl/comparator_seq_ctrl.sv
// ---------------------------------------------------------------------------
// comparator_seq_ctrl
// Multi-word unsigned magnitude compare using a single 2-bit slice comparator.
// Operands are walked MSB-first, one slice per clock; with EARLY_EXIT=1 the
// walk stops at the first unequal slice.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready=1 only in IDLE)
//   a, b                : WIDTH-bit operands, captured on accept
//   out_valid/out_ready : result handshake (out_valid=1 only in DONE)
//   a_gt_b/a_eq_b/a_lt_b: one-hot result while out_valid=1
//   busy                : 1 in RUN or DONE
//   slices              : number of slices examined for the current result
// ---------------------------------------------------------------------------
module comparator_seq_ctrl
    import cmp_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       a_gt_b,
    output logic                       a_eq_b,
    output logic                       a_lt_b,
    output logic                       busy,
    output logic [cw_of(WIDTH)-1:0]    slices
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int CW     = cw_of(WIDTH);
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
        $error("comparator_seq_ctrl: WIDTH must be even and >= 2");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_slices;
    logic [2:0]       r_res;     // published result, zero until DONE
    logic [2:0]       r_first;   // MSB-most unequal slice result seen so far

    logic [1:0]       w_sa;
    logic [1:0]       w_sb;
    logic             w_gt;
    logic             w_eq;
    logic             w_lt;
    logic [2:0]       w_slice_res;
    logic [2:0]       w_decided;
    logic             w_stop_early;
    logic             w_last;

    // Slice mux: pick the 2-bit slice selected by r_idx.
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_idx == IW'(i)) begin
                w_sa = r_a[2*i +: 2];
                w_sb = r_b[2*i +: 2];
            end
        end
    end

    cmp_slice2 u_slice (
        .i_a  (w_sa),
        .i_b  (w_sb),
        .o_gt (w_gt),
        .o_eq (w_eq),
        .o_lt (w_lt)
    );

    assign w_slice_res  = {w_gt, w_eq, w_lt};
    assign w_stop_early = (EARLY_EXIT != 0) && !w_eq;
    assign w_last       = (r_idx == '0);

    // Once an unequal slice has been seen, later slices cannot change the answer.
    always_comb begin
        w_decided = r_first;
        if ((r_first == RES_NONE) && !w_eq) begin
            w_decided = w_slice_res;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)                 w_state_nxt = ST_RUN;
            ST_RUN:  if (w_stop_early || w_last)   w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)                w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, slice walk and result latching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_slices <= '0;
            r_res    <= RES_NONE;
            r_first  <= RES_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_idx    <= IW'(NSLICE - 1);
                        r_slices <= '0;
                        r_res    <= RES_NONE;
                        r_first  <= RES_NONE;
                    end
                end
                ST_RUN: begin
                    r_slices <= r_slices + 1'b1;
                    if (w_stop_early) begin
                        r_res <= w_slice_res;
                    end else if (w_last) begin
                        r_res <= (w_decided == RES_NONE) ? RES_EQ : w_decided;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                        r_first <= w_decided;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
        a_gt_b    = r_res[2];
        a_eq_b    = r_res[1];
        a_lt_b    = r_res[0];
        slices    = r_slices;
    end

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_comparator_seq_ctrl
// Drives an EARLY_EXIT=1 and an EARLY_EXIT=0 instance with the same operand
// stream. Expected {gt,eq,lt}, slice count and latency are queued when an
// operation is launched and popped when each instance raises out_valid.
// ---------------------------------------------------------------------------
module tb_comparator_seq_ctrl;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] res1;
        int         sl1;
        logic [2:0] res0;
        int         sl0;
    } vec_t;

    typedef struct {
        logic [2:0] res;
        int         sl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;

    logic       in_ready_e1, out_valid_e1, gt_e1, eq_e1, lt_e1, busy_e1;
    logic       in_ready_e0, out_valid_e0, gt_e0, eq_e0, lt_e0, busy_e0;
    logic [2:0] slices_e1, slices_e0;
    logic [2:0] f1, f0;

    assign f1 = {gt_e1, eq_e1, lt_e1};
    assign f0 = {gt_e0, eq_e0, lt_e0};

    exp_t q1[$];
    exp_t q0[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    comparator_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) dut_e1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e1),
        .a(a), .b(b), .out_valid(out_valid_e1), .out_ready(out_ready),
        .a_gt_b(gt_e1), .a_eq_b(eq_e1), .a_lt_b(lt_e1), .busy(busy_e1),
        .slices(slices_e1)
    );

    comparator_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) dut_e0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e0),
        .a(a), .b(b), .out_valid(out_valid_e0), .out_ready(out_ready),
        .a_gt_b(gt_e0), .a_eq_b(eq_e0), .a_lt_b(lt_e0), .busy(busy_e0),
        .slices(slices_e0)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: MSB-first walk, first unequal slice decides.
    task automatic model(input logic [7:0] va, input logic [7:0] vb, input bit ee,
                         output logic [2:0] res, output int sl);
        logic [1:0] sa, sb;
        res = 3'b000;
        sl  = 0;
        for (int i = 3; i >= 0; i--) begin
            sa = va[2*i +: 2];
            sb = vb[2*i +: 2];
            sl++;
            if (sa != sb && res == 3'b000) res = (sa > sb) ? GT : LT;
            if (ee && res != 3'b000) break;
        end
        if (res == 3'b000) res = EQ;
    endtask

    // Launch one operation, check both results, optionally hold DONE for
    // 'hold' cycles with in_valid=1, then release with out_ready.
    task automatic do_op(input logic [7:0] va, input logic [7:0] vb,
                         input logic [2:0] r1, input int s1,
                         input logic [2:0] r0, input int s0, input int hold);
        exp_t e;
        exp_t g1;
        exp_t g0;
        int   lat1 = -1;
        int   lat0 = -1;
        e.res = r1; e.sl = s1; q1.push_back(e);
        e.res = r0; e.sl = s0; q0.push_back(e);

        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1;
        chk("in_ready_e1_before_accept", in_ready_e1, 1);
        chk("in_ready_e0_before_accept", in_ready_e0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        chk("busy_e1_after_accept", busy_e1, 1);
        chk("busy_e0_after_accept", busy_e0, 1);
        chk("in_ready_e1_after_accept", in_ready_e1, 0);
        chk("out_valid_e0_after_accept", out_valid_e0, 0);
        chk("flags_e1_cleared", f1, 0);
        chk("flags_e0_cleared", f0, 0);

        // n counts edges after the accept edge.
        for (int n = 1; n <= 12 && (lat1 < 0 || lat0 < 0); n++) begin
            @(posedge clk);
            #1;
            if (lat1 < 0 && out_valid_e1) begin
                lat1 = n;
                g1 = q1.pop_front();
                chk("flags_e1", f1, g1.res);
                chk("slices_e1", slices_e1, g1.sl);
                chk("latency_e1", lat1, g1.sl);
            end
            if (lat0 < 0 && out_valid_e0) begin
                lat0 = n;
                g0 = q0.pop_front();
                chk("flags_e0", f0, g0.res);
                chk("slices_e0", slices_e0, g0.sl);
                chk("latency_e0", lat0, g0.sl);
            end
        end
        if (lat1 < 0) begin chk("timeout_e1", 0, 1); void'(q1.pop_front()); end
        if (lat0 < 0) begin chk("timeout_e0", 0, 1); void'(q0.pop_front()); end

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 8'h5A; b = 8'hA5;
            @(posedge clk);
            #1;
            chk("hold_out_valid_e1", out_valid_e1, 1);
            chk("hold_in_ready_e1", in_ready_e1, 0);
            chk("hold_flags_e1", f1, r1);
            chk("hold_slices_e1", slices_e1, s1);
            chk("hold_flags_e0", f0, r0);
            chk("hold_in_ready_e0", in_ready_e0, 0);
        end

        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_in_ready_e1", in_ready_e1, 1);
        chk("release_in_ready_e0", in_ready_e0, 1);
        chk("release_out_valid_e1", out_valid_e1, 0);
        chk("release_busy_e0", busy_e0, 0);
        chk("idle_flags_kept_e1", f1, r1);
        chk("idle_slices_kept_e0", slices_e0, s0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] mr1;
        logic [2:0] mr0;
        int         ms1;
        int         ms0;

        vecs[0] = '{8'hC3, 8'h43, GT, 1, GT, 4};
        vecs[1] = '{8'hA5, 8'hA5, EQ, 4, EQ, 4};
        vecs[2] = '{8'h12, 8'h13, LT, 4, LT, 4};
        vecs[3] = '{8'h00, 8'hFF, LT, 1, LT, 4};
        vecs[4] = '{8'h80, 8'h7F, GT, 1, GT, 4};
        vecs[5] = '{8'h1C, 8'h20, LT, 2, LT, 4};
        vecs[6] = '{8'hFF, 8'hFF, EQ, 4, EQ, 4};
        vecs[7] = '{8'h01, 8'h00, GT, 4, GT, 4};

        // Reset state, with a handshake attempt that must be ignored.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a = 8'hC3; b = 8'h43;
        #3;
        chk("rst_out_valid_e1", out_valid_e1, 0);
        chk("rst_flags_e1", f1, 0);
        chk("rst_busy_e1", busy_e1, 0);
        chk("rst_in_ready_e1", in_ready_e1, 1);
        chk("rst_slices_e1", slices_e1, 0);
        chk("rst_flags_e0", f0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_held_busy_e0", busy_e0, 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;

        // Table vectors; vector 0 holds DONE for 3 cycles, vector 1 is
        // accepted the cycle right after the release.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].res1, vecs[i].sl1,
                  vecs[i].res0, vecs[i].sl0, (i == 0) ? 3 : 0);
        end

        // Reset during RUN after two slices of an all-equal compare.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrun_slices_e1", slices_e1, 2);
        chk("midrun_out_valid_e1", out_valid_e1, 0);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("abort_out_valid_e1", out_valid_e1, 0);
        chk("abort_busy_e1", busy_e1, 0);
        chk("abort_in_ready_e1", in_ready_e1, 1);
        chk("abort_slices_e1", slices_e1, 0);
        chk("abort_flags_e1", f1, 0);
        chk("abort_slices_e0", slices_e0, 0);
        chk("abort_busy_e0", busy_e0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            chk("no_result_after_abort", out_valid_e1 | out_valid_e0, 0);
        end
        do_op(8'h01, 8'h00, GT, 4, GT, 4, 0);

        // Random operands against the reference.
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = (i % 3 == 0) ? ra : 8'($urandom);
            model(ra, rb, 1'b1, mr1, ms1);
            model(ra, rb, 1'b0, mr0, ms0);
            do_op(ra, rb, mr1, ms1, mr0, ms0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
